// File: rtl/filtro_pkg.sv
// filtro_pkg
// Shared definitions for the IIR filter controller and its datapath:
// FSM state encoding, products per output sample, and the Sel operand
// indices used to pick coefficient/operand pairs in the shared MAC.
package filtro_pkg;

    // Products per output sample: u[k], u[k-1], u[k-2], y[k-1], y[k-2]
    localparam int NUM_PROD = 5;

    // Sel operand / coefficient indices
    localparam logic [2:0] IDX_U0 = 3'd0;
    localparam logic [2:0] IDX_U1 = 3'd1;
    localparam logic [2:0] IDX_U2 = 3'd2;
    localparam logic [2:0] IDX_Y1 = 3'd3;
    localparam logic [2:0] IDX_Y2 = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CARGA     = 3'd1,
        MAC       = 3'd2,
        ACTUALIZA = 3'd3,
        LISTO     = 3'd4
    } estado_t;

endpackage

// File: rtl/detector_flanco.sv
// detector_flanco
// Rising-edge detector. The previous-value register resets to RST_VAL so
// the caller decides whether a level already high at reset release counts
// as an edge.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   d      - level input
//   flanco - combinational pulse, d=1 while registered previous d=0
module detector_flanco #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic flanco
);

    logic d_prev;

    always_ff @(posedge clk) begin
        if (rst) d_prev <= RST_VAL;
        else     d_prev <= d;
    end

    assign flanco = d & ~d_prev;

endmodule

// File: rtl/control_filtro_iir.sv
// control_filtro_iir
// Sequencer for a single-MAC IIR filter. Each ADC sample start walks
// IDLE -> CARGA -> MAC (NUM_PROD cycles) -> ACTUALIZA -> LISTO. One extra
// start may be queued in a one-deep pending flag; a start arriving while
// that flag is already set is dropped and flagged on Error_Overrun.
// Ports:
//   Clk, Reset      - clock, synchronous active-high reset
//   Bandera_ADC     - ADC sample-valid level (rising edge = start)
//   En_Uk, Clr_Acum - load input sample, clear accumulator (CARGA)
//   En_Acum, Sel    - accumulate product of operand/coefficient Sel (MAC)
//   Resta           - subtract product (feedback terms y[k-1], y[k-2])
//   En_Yk, En_Retardo - load saturated Yk, shift delay lines (ACTUALIZA)
//   Bandera_Listo   - new Yk valid (LISTO)
//   Error_Overrun   - a start was dropped
module control_filtro_iir #(
    parameter int NUM_PROD = filtro_pkg::NUM_PROD,
    parameter int SEL_W    = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Bandera_ADC,
    output logic             En_Uk,
    output logic             Clr_Acum,
    output logic             En_Acum,
    output logic [SEL_W-1:0] Sel,
    output logic             Resta,
    output logic             En_Yk,
    output logic             En_Retardo,
    output logic             Bandera_Listo,
    output logic             Error_Overrun
);
    import filtro_pkg::*;

    localparam logic [SEL_W-1:0] ULTIMO = SEL_W'(NUM_PROD - 1);

    estado_t          estado, estado_n;
    logic [SEL_W-1:0] cnt, cnt_n;
    logic             pend, pend_n;
    logic             overrun_n;
    logic             inicio;

    // Previous ADC level resets high: a level held across reset is not a start
    detector_flanco #(.RST_VAL(1'b1)) u_flanco (
        .clk    (Clk),
        .rst    (Reset),
        .d      (Bandera_ADC),
        .flanco (inicio)
    );

    always_comb begin
        estado_n  = estado;
        cnt_n     = cnt;
        pend_n    = pend;
        overrun_n = 1'b0;

        // Starts outside IDLE queue one deep; beyond that they are lost
        if (inicio && estado != IDLE) begin
            if (pend) overrun_n = 1'b1;
            else      pend_n    = 1'b1;
        end

        case (estado)
            IDLE: begin
                if (inicio || pend) begin
                    estado_n = CARGA;
                    // Serving a pending sample while a new start arrives
                    // leaves the new one queued
                    pend_n   = inicio & pend;
                end
            end
            CARGA: begin
                estado_n = MAC;
                cnt_n    = '0;
            end
            MAC: begin
                if (cnt == ULTIMO) begin
                    estado_n = ACTUALIZA;
                    cnt_n    = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ACTUALIZA: estado_n = LISTO;
            LISTO: begin
                if (pend) begin
                    estado_n = CARGA;
                    pend_n   = 1'b0;
                end else begin
                    // A start seen here with pend=0 set pend above, so
                    // IDLE hands it straight to CARGA next cycle
                    estado_n = IDLE;
                end
            end
            default: begin
                estado_n = IDLE;
                cnt_n    = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register: effectively a Moore decode of (estado, cnt).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            estado        <= IDLE;
            cnt           <= '0;
            pend          <= 1'b0;
            En_Uk         <= 1'b0;
            Clr_Acum      <= 1'b0;
            En_Acum       <= 1'b0;
            Sel           <= '0;
            Resta         <= 1'b0;
            En_Yk         <= 1'b0;
            En_Retardo    <= 1'b0;
            Bandera_Listo <= 1'b0;
            Error_Overrun <= 1'b0;
        end else begin
            estado        <= estado_n;
            cnt           <= cnt_n;
            pend          <= pend_n;
            En_Uk         <= (estado_n == CARGA);
            Clr_Acum      <= (estado_n == CARGA);
            En_Acum       <= (estado_n == MAC);
            Sel           <= (estado_n == MAC) ? cnt_n : '0;
            Resta         <= (estado_n == MAC) && (cnt_n >= SEL_W'(IDX_Y1));
            En_Yk         <= (estado_n == ACTUALIZA);
            En_Retardo    <= (estado_n == ACTUALIZA);
            Bandera_Listo <= (estado_n == LISTO);
            Error_Overrun <= overrun_n;
        end
    end

endmodule

// File: tb/tb_control_filtro_iir.sv
// tb_control_filtro_iir
// Directed scenarios with hand-computed cycle numbers. Each scenario runs
// Reset for cycles 0..2, drives Bandera_ADC from a per-cycle table, and
// logs the packed outputs of every cycle for checking afterwards.
// Packed output word: {En_Uk, Clr_Acum, En_Acum, Sel[2:0], Resta,
//                      En_Yk, En_Retardo, Bandera_Listo, Error_Overrun}
module tb_control_filtro_iir;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Bandera_ADC = 1'b0;
    logic       En_Uk, Clr_Acum, En_Acum, Resta, En_Yk, En_Retardo;
    logic       Bandera_Listo, Error_Overrun;
    logic [2:0] Sel;

    int n_tests = 0;
    int n_fail  = 0;

    logic [10:0] outv [0:511];

    localparam logic [10:0] M_LISTO = 11'b000_0000_0010;
    localparam logic [10:0] M_OVR   = 11'b000_0000_0001;
    localparam logic [10:0] M_CARGA = 11'b100_0000_0000;
    localparam logic [10:0] M_ALL   = 11'h7FF;

    control_filtro_iir #(.NUM_PROD(5), .SEL_W(3)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Bandera_ADC   (Bandera_ADC),
        .En_Uk         (En_Uk),
        .Clr_Acum      (Clr_Acum),
        .En_Acum       (En_Acum),
        .Sel           (Sel),
        .Resta         (Resta),
        .En_Yk         (En_Yk),
        .En_Retardo    (En_Retardo),
        .Bandera_Listo (Bandera_Listo),
        .Error_Overrun (Error_Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] mk(input bit uk, input bit clr, input bit acc,
                                       input int sel, input bit resta, input bit yk,
                                       input bit ret, input bit listo, input bit ovr);
        return {uk, clr, acc, 3'(sel), resta, yk, ret, listo, ovr};
    endfunction

    function automatic logic adc_f(input int sc, input int c);
        case (sc)
            1: return (c >= 10 && c < 50);
            2: return (c >= 10 && c < 210);
            3: return (c >= 10 && c < 12) || (c >= 14 && c < 16);
            4: return (c == 10) || (c == 13) || (c == 16);
            5: return (c >= 10 && c < 41) || (c >= 45 && c < 60);
            6: return (c < 21) || (c >= 25 && c < 40);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rst_f(input int sc, input int c);
        return (c < 3) || (sc == 5 && c == 14);
    endfunction

    // Number of cycles in [lo,hi] where any masked output bit is set
    function automatic int cuenta(input int lo, input int hi, input logic [10:0] m);
        int n = 0;
        for (int c = lo; c <= hi; c++)
            if ((outv[c] & m) != 0) n++;
        return n;
    endfunction

    task automatic run(input int sc, input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge Clk);
            #1;
            Reset       = rst_f(sc, c);
            Bandera_ADC = adc_f(sc, c);
            @(negedge Clk);
            outv[c] = {En_Uk, Clr_Acum, En_Acum, Sel, Resta,
                       En_Yk, En_Retardo, Bandera_Listo, Error_Overrun};
        end
    endtask

    initial begin
        // Single start: rise at 10, held
        run(1, 60);
        chk("s1_reset", outv[2], 11'd0);
        chk("s1_idle", cuenta(3, 10, M_ALL), 0);
        chk("s1_carga", outv[11], mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 5; i++)
            chk($sformatf("s1_mac%0d", i), outv[12 + i], mk(0, 0, 1, i, i >= 3, 0, 0, 0, 0));
        chk("s1_actualiza", outv[17], mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
        chk("s1_listo", outv[18], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("s1_quiet", cuenta(19, 59, M_ALL), 0);

        // Level held 200 cycles: one sample only
        run(2, 230);
        chk("s2_reset", outv[2], 11'd0);
        chk("s2_listo18", outv[18], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("s2_nlisto", cuenta(0, 229, M_LISTO), 1);

        // Back-to-back: second rise during MAC is queued
        run(3, 40);
        chk("s3_listo18", outv[18], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("s3_carga19", outv[19], mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("s3_listo26", outv[26], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("s3_nlisto", cuenta(0, 39, M_LISTO), 2);
        chk("s3_novr", cuenta(0, 39, M_OVR), 0);

        // Overrun: third rise while one is already pending
        run(4, 40);
        chk("s4_ovr17", outv[17], mk(0, 0, 0, 0, 0, 1, 1, 0, 1));
        chk("s4_novr", cuenta(0, 39, M_OVR), 1);
        chk("s4_listo26", outv[26], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("s4_nlisto", cuenta(0, 39, M_LISTO), 2);

        // Reset mid-MAC, ADC still high afterwards, then a fresh rise at 45
        run(5, 60);
        chk("s5_mac14", outv[14], mk(0, 0, 1, 2, 0, 0, 0, 0, 0));
        chk("s5_quiet", cuenta(15, 45, M_ALL), 0);
        chk("s5_carga46", outv[46], mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("s5_listo53", outv[53], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("s5_nlisto", cuenta(0, 59, M_LISTO), 1);

        // ADC high through reset release: start only on the later rise
        run(6, 40);
        chk("s6_quiet", cuenta(1, 25, M_ALL), 0);
        chk("s6_carga26", outv[26], mk(1, 1, 0, 0, 0, 0, 0, 0, 0));
        chk("s6_listo33", outv[33], mk(0, 0, 0, 0, 0, 0, 0, 1, 0));
        chk("s6_ncarga", cuenta(0, 39, M_CARGA), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
